// File: rtl/udma_cfg_pkg.sv
// Shared types and field positions for the APB to uDMA cfg-bus bridge.
package udma_cfg_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE} cfg_br_state_e;

  localparam int CFG_REG_LSB = 2;
  localparam int CFG_REG_W   = 5;
  localparam int CFG_PER_LSB = 7;
  localparam int CFG_DATA_W  = 32;

  // Counter must hold TIMEOUT_CYCLES-1; 8 bits cover up to 256 cycles.
  function automatic int cfg_cnt_width(input int cycles);
    return (cycles > 256) ? 16 : 8;
  endfunction

endpackage

// File: rtl/udma_cfg_timeout_cnt.sv
// Cycle counter for a stalled cfg-bus request; expired_o flags count == TIMEOUT_CYCLES-1.
module udma_cfg_timeout_cnt
  import udma_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = cfg_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/udma_apb_cfg_bridge.sv
// APB3 slave driving the uDMA peripheral cfg bus; one registered request per APB transfer.
// Optional request timeout enabled with `UDMA_CFG_TIMEOUT_EN.
module udma_apb_cfg_bridge
  import udma_cfg_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_PERIPHS      = 4,
  parameter int PER_ID_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0]       paddr_i,
  input  logic [31:0]                     pwdata_i,
  input  logic                            pwrite_i,
  input  logic                            psel_i,
  input  logic                            penable_i,
  output logic [31:0]                     prdata_o,
  output logic                            pready_o,
  output logic                            pslverr_o,
  output logic [31:0]                     cfg_data_o,
  output logic [4:0]                      cfg_addr_o,
  output logic                            cfg_rwn_o,
  output logic [N_PERIPHS-1:0]            cfg_valid_o,
  input  logic [32*N_PERIPHS-1:0]         cfg_data_i,
  input  logic [N_PERIPHS-1:0]            cfg_ready_i
);

  cfg_br_state_e           state_q, state_d;
  logic [PER_ID_WIDTH-1:0] id_q, id_d;
  logic [CFG_REG_W-1:0]    addr_q, addr_d;
  logic [CFG_DATA_W-1:0]   data_q, data_d;
  logic [CFG_DATA_W-1:0]   prdata_q, prdata_d;
  logic                    rwn_q, rwn_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [N_PERIPHS-1:0]    valid_q, valid_d;

  logic [PER_ID_WIDTH-1:0] req_id;
  logic                    sel_ready;
  logic [CFG_DATA_W-1:0]   sel_rdata;
  logic                    timeout;
  logic                    unused_paddr;

  assign req_id       = paddr_i[CFG_PER_LSB +: PER_ID_WIDTH];
  assign unused_paddr = ^{paddr_i[CFG_REG_LSB-1:0],
                          paddr_i[APB_ADDR_WIDTH-1:CFG_PER_LSB+PER_ID_WIDTH]};

  // Only the latched responder's ready and data are ever looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < N_PERIPHS; k++) begin
      if (id_q == PER_ID_WIDTH'(k)) begin
        sel_ready = cfg_ready_i[k];
        sel_rdata = cfg_data_i[k*CFG_DATA_W +: CFG_DATA_W];
      end
    end
  end

`ifdef UDMA_CFG_TIMEOUT_EN
  udma_cfg_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clear_i   (state_q != REQ),
    .enable_i  ((state_q == REQ) && !sel_ready),
    .expired_o (timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rwn_d     = rwn_q;
    valid_d   = valid_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = pslverr_q;
    case (state_q)
      IDLE: begin
        if (psel_i && penable_i) begin
          id_d   = req_id;
          addr_d = paddr_i[CFG_REG_LSB +: CFG_REG_W];
          data_d = pwdata_i;
          rwn_d  = ~pwrite_i;
          if (32'(req_id) < N_PERIPHS) begin
            state_d = REQ;
            for (int k = 0; k < N_PERIPHS; k++) begin
              valid_d[k] = (req_id == PER_ID_WIDTH'(k));
            end
          end else begin
            // No responder behind this index: fail the transfer without touching the cfg bus.
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end
        end
      end
      REQ: begin
        if (sel_ready) begin
          state_d   = DONE;
          valid_d   = '0;
          pready_d  = 1'b1;
          pslverr_d = 1'b0;
          prdata_d  = rwn_q ? sel_rdata : '0;
        end else if (timeout) begin
          state_d   = DONE;
          valid_d   = '0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end
      end
      DONE: begin
        state_d   = IDLE;
        pslverr_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rwn_q     <= 1'b0;
      valid_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rwn_q     <= rwn_d;
      valid_q   <= valid_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata_o    = prdata_q;
  assign pready_o    = pready_q;
  assign pslverr_o   = pslverr_q;
  assign cfg_data_o  = data_q;
  assign cfg_addr_o  = addr_q;
  assign cfg_rwn_o   = rwn_q;
  assign cfg_valid_o = valid_q;

endmodule
